uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the UART transmit write port among NREQ hardware requesters, for example the processor path and autonomous message sources. It accepts one byte per request through a valid/ack handshake and issues a single-cycle write strobe with the byte. It then tracks the UART's TXRDY handshake so that no byte is written while the transmitter is busy. The block sits between the requesters and the UART's Write/OUT_PORT inputs; the TXRDY status is fed back from the UART.

---
 rtl/uart_pkg.sv | 16 +
 rtl/rr_pick.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 155 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit-side blocks.
// Holds the sequencer state encoding and the default byte width and TXRDY timeout.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WAIT_LO,
        WAIT_HI,
        HOLD
    } state_e;

    localparam int DW_DEF  = 8;
    localparam int TMO_DEF = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority encoder: finds the first set request at or above ptr,
// wrapping modulo NREQ. Returns the winner as both a one-hot vector and an index.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [IW-1:0]   index
);

    logic found;
    int   pos;

    always_comb begin
        onehot = '0;
        index  = '0;
        found  = 1'b0;
        pos    = 0;
        for (int k = 0; k < NREQ; k++) begin
            pos = (int'(ptr) + k) % NREQ;
            if (!found && req[pos]) begin
                found       = 1'b1;
                onehot[pos] = 1'b1;
                index       = pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the UART transmit write port among NREQ requesters.
// Issues one registered write strobe per byte and paces writes on the UART TXRDY handshake.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = DW_DEF,
    parameter int TMO  = TMO_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    lock,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    ack,
    output logic [NREQ-1:0]    gnt,
    input  logic             TXRDY,
    output logic             tx_write,
    output logic [DW-1:0]    tx_data,
    output logic             busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;

    state_e          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]   gnt_idx_q, gnt_idx_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            tx_write_q, tx_write_d;
    logic [DW-1:0]   tx_data_q, tx_data_d;
    logic            busy_q, busy_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;

    logic [NREQ-1:0] pick_onehot;
    logic [IW-1:0]   pick_index;
    logic            own_req;
    logic            own_lock;
    logic [DW-1:0]   own_data;
    logic [IW-1:0]   next_ptr;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req    (req),
        .ptr    (rr_ptr_q),
        .onehot (pick_onehot),
        .index  (pick_index)
    );

    assign own_req  = req[gnt_idx_q];
    assign own_lock = lock[gnt_idx_q];
    assign own_data = req_data[int'(gnt_idx_q)*DW +: DW];
    assign next_ptr = (gnt_idx_q == IW'(NREQ-1)) ? '0 : gnt_idx_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_idx_d  = gnt_idx_q;
        ack_d      = '0;
        tx_write_d = 1'b0;
        tx_data_d  = tx_data_q;
        rr_ptr_d   = rr_ptr_q;
        tmo_cnt_d  = tmo_cnt_q;

        unique case (state_q)
            IDLE: begin
                if ((|req) && TXRDY) begin
                    gnt_d     = pick_onehot;
                    gnt_idx_d = pick_index;
                    tx_data_d = req_data[int'(pick_index)*DW +: DW];
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                tx_write_d = 1'b1;
                ack_d      = gnt_q;
                tmo_cnt_d  = '0;
                state_d    = WAIT_LO;
            end
            // A UART that never drops TXRDY is assumed to have taken the byte after TMO cycles.
            WAIT_LO: begin
                if (!TXRDY || (tmo_cnt_q == TW'(TMO-1))) begin
                    state_d = WAIT_HI;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            WAIT_HI: begin
                if (TXRDY) begin
                    if (own_lock && own_req) begin
                        tx_data_d = own_data;
                        state_d   = WRITE;
                    end else if (own_lock) begin
                        state_d = HOLD;
                    end else begin
                        gnt_d    = '0;
                        rr_ptr_d = next_ptr;
                        state_d  = IDLE;
                    end
                end
            end
            // Dropping lock wins over a pending byte, so the owner is released as unlocked.
            HOLD: begin
                if (!own_lock) begin
                    gnt_d    = '0;
                    rr_ptr_d = next_ptr;
                    state_d  = IDLE;
                end else if (own_req) begin
                    tx_data_d = own_data;
                    state_d   = WRITE;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            gnt_idx_q  <= '0;
            ack_q      <= '0;
            tx_write_q <= 1'b0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
            rr_ptr_q   <= '0;
            tmo_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_idx_q  <= gnt_idx_d;
            ack_q      <= ack_d;
            tx_write_q <= tx_write_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            rr_ptr_q   <= rr_ptr_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

    assign gnt      = gnt_q;
    assign ack      = ack_q;
    assign tx_write = tx_write_q;
    assign tx_data  = tx_data_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requesters feed byte queues, a UART model
// paces TXRDY, and every observed write is checked against the expected order.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int TMO  = 16;

    typedef struct {
        int             idx;
        logic [DW-1:0]  data;
    } exp_t;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    lock;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    ack;
    logic [NREQ-1:0]    gnt;
    logic              TXRDY;
    logic              tx_write;
    logic [DW-1:0]     tx_data;
    logic              busy;

    exp_t          sbQ[$];
    logic [DW-1:0] byteQ[NREQ][$];
    logic [NREQ-1:0] lockOn;
    logic          uartModelOn;
    logic          dropPending;
    int            hiCount;
    int            cycle;
    int            writeCount;
    int            lastWriteCycle;
    int            prevWriteCycle;
    int            compared;
    int            mismatched;

    uart_tx_arbiter #(
        .NREQ (NREQ),
        .DW   (DW),
        .TMO  (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .lock     (lock),
        .req_data (req_data),
        .ack      (ack),
        .gnt      (gnt),
        .TXRDY    (TXRDY),
        .tx_write (tx_write),
        .tx_data  (tx_data),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, observed, expected, cycle);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic [DW-1:0] data);
        exp_t e;
        e.idx  = idx;
        e.data = data;
        sbQ.push_back(e);
        byteQ[idx].push_back(data);
    endtask

    task automatic waitDone(input string tag, input int maxCycles);
        int n;
        n = 0;
        while ((sbQ.size() != 0 || busy) && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, " drained"}, 32'(n < maxCycles), 32'd1);
    endtask

    // Requesters present the head of their byte queue and retire it on ack.
    always @(negedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (rst && ack[i] && byteQ[i].size() != 0) void'(byteQ[i].pop_front());
        end
        for (int i = 0; i < NREQ; i++) begin
            req[i]              = (byteQ[i].size() != 0);
            req_data[i*DW +: DW] = (byteQ[i].size() != 0) ? byteQ[i][0] : '0;
            lock[i]             = lockOn[i];
        end
    end

    // UART model: TXRDY drops one cycle after a write and rises again ten cycles later.
    always @(negedge clk) begin
        if (!rst) begin
            dropPending = 1'b0;
            hiCount     = 0;
        end else if (uartModelOn) begin
            if (hiCount > 0) begin
                hiCount--;
                if (hiCount == 0) TXRDY = 1'b1;
            end
            if (dropPending) begin
                TXRDY       = 1'b0;
                hiCount     = 10;
                dropPending = 1'b0;
            end
            if (tx_write) dropPending = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst && tx_write) begin
            exp_t e;
            writeCount++;
            prevWriteCycle = lastWriteCycle;
            lastWriteCycle = cycle;
            if (sbQ.size() == 0) begin
                checkOutput("unexpected write", 32'd1, 32'd0);
            end else begin
                e = sbQ.pop_front();
                checkOutput("tx_data", 32'(tx_data), 32'(e.data));
                checkOutput("ack", 32'(ack), 32'(1) << e.idx);
                checkOutput("gnt", 32'(gnt), 32'(1) << e.idx);
            end
        end else if (rst && ack != '0) begin
            checkOutput("ack without write", 32'(ack), 32'd0);
        end
    end

    initial begin
        int wc;
        int n;
        compared       = 0;
        mismatched     = 0;
        cycle          = 0;
        writeCount     = 0;
        lastWriteCycle = 0;
        prevWriteCycle = 0;
        lockOn         = '0;
        uartModelOn    = 1'b1;
        dropPending    = 1'b0;
        hiCount        = 0;
        req            = '0;
        lock           = '0;
        req_data       = '0;
        TXRDY          = 1'b1;
        rst            = 1'b0;

        // Reset with all four requesting, then round-robin order 0,1,2,3,0.
        applyStimulus(0, 8'hA0);
        applyStimulus(1, 8'hA1);
        applyStimulus(2, 8'hA2);
        applyStimulus(3, 8'hA3);
        applyStimulus(0, 8'hB0);
        repeat (4) @(negedge clk);
        checkOutput("reset gnt", 32'(gnt), 32'd0);
        checkOutput("reset tx_write", 32'(tx_write), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset ack", 32'(ack), 32'd0);
        checkOutput("reset tx_data", 32'(tx_data), 32'd0);
        rst = 1'b1;
        waitDone("round robin", 400);

        // Locked packet from requester 2 while requester 0 waits.
        @(negedge clk);
        lockOn[2] = 1'b1;
        applyStimulus(2, 8'h11);
        applyStimulus(2, 8'h22);
        applyStimulus(2, 8'h33);
        applyStimulus(0, 8'hC0);
        n = 0;
        while (byteQ[2].size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("lock bytes taken", 32'(n < 300), 32'd1);
        repeat (25) @(negedge clk);
        checkOutput("hold gnt", 32'(gnt), 32'b0100);
        checkOutput("hold busy", 32'(busy), 32'd1);
        checkOutput("hold pending", 32'(sbQ.size()), 32'd1);
        lockOn[2] = 1'b0;
        waitDone("lock release", 200);

        // UART busy for 50 cycles, then write two cycles after TXRDY rises.
        @(negedge clk);
        uartModelOn = 1'b0;
        TXRDY       = 1'b0;
        applyStimulus(1, 8'hD1);
        wc = writeCount;
        repeat (50) @(negedge clk);
        checkOutput("busy uart writes", 32'(writeCount - wc), 32'd0);
        checkOutput("busy uart gnt", 32'(gnt), 32'd0);
        checkOutput("busy uart ack", 32'(ack), 32'd0);
        TXRDY       = 1'b1;
        uartModelOn = 1'b1;
        @(negedge clk);
        checkOutput("txrdy+1 tx_write", 32'(tx_write), 32'd0);
        @(negedge clk);
        checkOutput("txrdy+2 tx_write", 32'(tx_write), 32'd1);
        waitDone("busy uart", 200);

        // TXRDY stuck high: each byte leaves WAIT_LO on the timeout.
        @(negedge clk);
        uartModelOn = 1'b0;
        TXRDY       = 1'b1;
        applyStimulus(3, 8'hE0);
        applyStimulus(3, 8'hE1);
        waitDone("timeout", 200);
        checkOutput("timeout write gap", 32'(lastWriteCycle - prevWriteCycle), 32'd19);

        // Reset during WAIT_HI of a locked transfer; pointer must restart at 0.
        @(negedge clk);
        uartModelOn = 1'b1;
        applyStimulus(2, 8'h5A);
        waitDone("pre-reset byte", 200);
        @(negedge clk);
        lockOn[1] = 1'b1;
        applyStimulus(1, 8'hF0);
        byteQ[1].push_back(8'hF1);
        wc = writeCount;
        n  = 0;
        while ((writeCount == wc || TXRDY) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("locked write seen", 32'(n < 200), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("midreset gnt", 32'(gnt), 32'd0);
        checkOutput("midreset busy", 32'(busy), 32'd0);
        checkOutput("midreset tx_write", 32'(tx_write), 32'd0);
        checkOutput("midreset ack", 32'(ack), 32'd0);
        checkOutput("midreset tx_data", 32'(tx_data), 32'd0);
        sbQ.delete();
        byteQ[1].delete();
        lockOn[1] = 1'b0;
        TXRDY     = 1'b1;
        repeat (2) @(negedge clk);
        applyStimulus(0, 8'h60);
        applyStimulus(3, 8'h63);
        @(negedge clk);
        rst = 1'b1;
        waitDone("post reset", 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
